// File: rtl/nbody_pair_scheduler.sv
// nbody_pair_scheduler
// Sequences the pipelined force calculator for one N-body timestep. For each
// outer body i it issues every j != i to the force pipeline, keeping up to
// MAX_OUTSTANDING pairs in flight. Once every result of row i has returned,
// it hands the row to the update stage. Rows never overlap.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             begin a timestep (honoured only in IDLE or DONE)
//   busy, done        status: working / timestep complete (held)
//   pair_valid/ready  pair handshake carrying pair_i, pair_j, pair_first, pair_last
//   res_valid         one force result returned this cycle
//   row_valid/ready   row handshake carrying row_idx
//   outstanding       pairs issued but not yet returned
//   err               sticky: result received with nothing outstanding
module nbody_pair_scheduler #(
    parameter int unsigned N               = 16,
    parameter int unsigned IDX_W           = $clog2(N),
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             pair_first,
    output logic             pair_last,
    input  logic             res_valid,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [IDX_W-1:0] row_idx,
    output logic [CNT_W-1:0] outstanding,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_ISSUE = IDX_W'(N - 2);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_ROW_DONE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy_d, done_d, pair_valid_d, pair_first_d, pair_last_d, row_valid_d;
    logic             hs;

    assign hs = pair_valid && pair_ready;

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        // Issue and return in the same cycle cancel; a stray return is flagged
        if (hs && !res_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!hs && res_valid && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (res_valid && (cnt_q == '0)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    i_d      = '0;
                    j_d      = IDX_W'(1);
                    issued_d = '0;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    issued_d = issued_q + IDX_W'(1);
                    // Hop over the diagonal without spending a cycle
                    j_d = ((j_q + IDX_W'(1)) == i_q) ? (j_q + IDX_W'(2)) : (j_q + IDX_W'(1));
                    if (pair_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = S_ROW_DONE;
                end
            end
            S_ROW_DONE: begin
                if (row_ready) begin
                    if (i_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        // New i is never 0 here, so the row always starts at j=0
                        state_d  = S_ISSUE;
                        i_d      = i_q + IDX_W'(1);
                        j_d      = '0;
                        issued_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_ROW_DONE);
        done_d       = (state_d == S_DONE);
        pair_valid_d = (state_d == S_ISSUE) && (cnt_d < MAX_CNT);
        pair_first_d = (state_d == S_ISSUE) && (issued_d == '0);
        pair_last_d  = (state_d == S_ISSUE) && (issued_d == LAST_ISSUE);
        row_valid_d  = (state_d == S_ROW_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            issued_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pair_valid <= 1'b0;
            pair_first <= 1'b0;
            pair_last  <= 1'b0;
            row_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            issued_q   <= issued_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy       <= busy_d;
            done       <= done_d;
            pair_valid <= pair_valid_d;
            pair_first <= pair_first_d;
            pair_last  <= pair_last_d;
            row_valid  <= row_valid_d;
        end
    end

    assign pair_i      = i_q;
    assign pair_j      = j_q;
    assign row_idx     = i_q;
    assign outstanding = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Bench for nbody_pair_scheduler: dut_a (N=4, MAX=8) runs the directed table
// and corner sequences; dut_b (N=4, MAX=2) runs alongside to exercise credit
// throttling, checked by a monitor.
module tb_nbody_pair_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CW_A  = 4;
    localparam int unsigned CW_B  = 2;

    typedef struct {
        int         stall;
        logic [1:0] ei;
        logic [1:0] ej;
        logic       ef;
        logic       el;
    } vec_t;

    vec_t vec [12];

    logic clk = 1'b0;
    logic reset;

    logic             start_a, pair_ready_a, row_ready_a, res_valid_a;
    logic             busy_a, done_a, pair_valid_a, pair_first_a, pair_last_a, row_valid_a, err_a;
    logic [IDX_W-1:0] pair_i_a, pair_j_a, row_idx_a;
    logic [CW_A-1:0]  outstanding_a;

    logic             start_b, pair_ready_b, row_ready_b, res_valid_b;
    logic             busy_b, done_b, pair_valid_b, pair_first_b, pair_last_b, row_valid_b, err_b;
    logic [IDX_W-1:0] pair_i_b, pair_j_b, row_idx_b;
    logic [CW_B-1:0]  outstanding_b;

    logic [5:0] pipe_a = '0;
    logic [5:0] pipe_b = '0;
    logic       auto_a;
    logic       res_man_a;
    logic       mon_en;

    int n_pass  = 0;
    int n_total = 0;
    int rows_a  = 0;
    int rows_b  = 0;
    int idx_b   = 0;

    always #5 clk = ~clk;

    nbody_pair_scheduler #(.N(N), .MAX_OUTSTANDING(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .pair_valid(pair_valid_a), .pair_ready(pair_ready_a), .pair_i(pair_i_a),
        .pair_j(pair_j_a), .pair_first(pair_first_a), .pair_last(pair_last_a),
        .res_valid(res_valid_a), .row_valid(row_valid_a), .row_ready(row_ready_a),
        .row_idx(row_idx_a), .outstanding(outstanding_a), .err(err_a)
    );

    nbody_pair_scheduler #(.N(N), .MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .pair_valid(pair_valid_b), .pair_ready(pair_ready_b), .pair_i(pair_i_b),
        .pair_j(pair_j_b), .pair_first(pair_first_b), .pair_last(pair_last_b),
        .res_valid(res_valid_b), .row_valid(row_valid_b), .row_ready(row_ready_b),
        .row_idx(row_idx_b), .outstanding(outstanding_b), .err(err_b)
    );

    // Force pipeline model: each accepted pair returns a result 6 cycles later
    always @(posedge clk) begin
        pipe_a <= {pipe_a[4:0], pair_valid_a && pair_ready_a};
        pipe_b <= {pipe_b[4:0], pair_valid_b && pair_ready_b};
    end
    assign res_valid_a = auto_a ? pipe_a[5] : res_man_a;
    assign res_valid_b = pipe_b[5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Row handshake monitor for dut_a
    always @(negedge clk) begin
        if (mon_en && row_valid_a && row_ready_a) begin
            chk("a_row_idx", 32'(row_idx_a), 32'(rows_a % 4));
            rows_a++;
        end
    end

    // dut_b monitor: pair order, credit limit, row order
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy_b) begin
                chk("b_out_le_max", 32'(outstanding_b <= 2'd2), 1);
                if (outstanding_b == 2'd2) chk("b_credit_stall", 32'(pair_valid_b), 0);
            end
            if (pair_valid_b && pair_ready_b) begin
                chk("b_pair_i", 32'(pair_i_b), 32'(vec[idx_b % 12].ei));
                chk("b_pair_j", 32'(pair_j_b), 32'(vec[idx_b % 12].ej));
                chk("b_first", 32'(pair_first_b), 32'(vec[idx_b % 12].ef));
                chk("b_last", 32'(pair_last_b), 32'(vec[idx_b % 12].el));
                idx_b++;
            end
            if (row_valid_b && row_ready_b) begin
                chk("b_row_idx", 32'(row_idx_b), 32'(rows_b % 4));
                rows_b++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic [1:0] hi, hj;

        vec[0]  = '{0, 2'd0, 2'd1, 1'b1, 1'b0};
        vec[1]  = '{2, 2'd0, 2'd2, 1'b0, 1'b0};
        vec[2]  = '{1, 2'd0, 2'd3, 1'b0, 1'b1};
        vec[3]  = '{0, 2'd1, 2'd0, 1'b1, 1'b0};
        vec[4]  = '{2, 2'd1, 2'd2, 1'b0, 1'b0};
        vec[5]  = '{0, 2'd1, 2'd3, 1'b0, 1'b1};
        vec[6]  = '{1, 2'd2, 2'd0, 1'b1, 1'b0};
        vec[7]  = '{3, 2'd2, 2'd1, 1'b0, 1'b0};
        vec[8]  = '{0, 2'd2, 2'd3, 1'b0, 1'b1};
        vec[9]  = '{2, 2'd3, 2'd0, 1'b1, 1'b0};
        vec[10] = '{0, 2'd3, 2'd1, 1'b0, 1'b0};
        vec[11] = '{1, 2'd3, 2'd2, 1'b0, 1'b1};

        reset = 1'b0; start_a = 0; start_b = 0; pair_ready_a = 0; pair_ready_b = 0;
        row_ready_a = 0; row_ready_b = 0; auto_a = 1; res_man_a = 0; mon_en = 0;

        // Reset values
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pair_valid", 32'(pair_valid_a), 0);
        chk("rst_pair_j", 32'(pair_j_a), 0);
        chk("rst_row_valid", 32'(row_valid_a), 0);
        chk("rst_outstanding", 32'(outstanding_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_b_pair_valid", 32'(pair_valid_b), 0);
        @(negedge clk); #1 reset = 1'b0;
        row_ready_a = 1; row_ready_b = 1; pair_ready_b = 1; mon_en = 1;

        // Two timesteps on dut_a: full rate, then with pair_ready stalls
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); #1 start_a = 1; if (p == 0) start_b = 1;
            @(negedge clk);
            if (p == 1) chk("a_done_drops", 32'(done_a), 0);
            #1 start_a = 0; start_b = 0;
            @(negedge clk);
            for (int k = 0; k < 12; k++) begin
                cyc = 0;
                while (!pair_valid_a && cyc < 64) begin
                    #1 pair_ready_a = 0;
                    @(negedge clk);
                    cyc++;
                end
                chk("a_valid_wait", 32'(pair_valid_a), 1);
                if (p == 0 && !vec[k].ef) chk("a_back_to_back", 32'(cyc), 0);
                if (p == 1) begin
                    for (int s = 0; s < vec[k].stall; s++) begin
                        hi = pair_i_a; hj = pair_j_a;
                        #1 pair_ready_a = 0;
                        @(negedge clk);
                        chk("a_stall_valid", 32'(pair_valid_a), 1);
                        chk("a_stall_i", 32'(pair_i_a), 32'(hi));
                        chk("a_stall_j", 32'(pair_j_a), 32'(hj));
                    end
                end
                chk("a_pair_i", 32'(pair_i_a), 32'(vec[k].ei));
                chk("a_pair_j", 32'(pair_j_a), 32'(vec[k].ej));
                chk("a_first", 32'(pair_first_a), 32'(vec[k].ef));
                chk("a_last", 32'(pair_last_a), 32'(vec[k].el));
                #1 pair_ready_a = 1;
                @(negedge clk);
            end
            #1 pair_ready_a = 0;
            cyc = 0;
            while (!done_a && cyc < 64) begin @(negedge clk); cyc++; end
            chk("a_done", 32'(done_a), 1);
            repeat (3) begin
                @(negedge clk);
                chk("a_done_held", 32'(done_a), 1);
                chk("a_idle_busy", 32'(busy_a), 0);
            end
            chk("a_rows", 32'(rows_a), 32'(4 * (p + 1)));
            chk("a_err_clean", 32'(err_a), 0);
        end

        cyc = 0;
        while (!done_b && cyc < 200) begin @(negedge clk); cyc++; end
        chk("b_done", 32'(done_b), 1);
        chk("b_pairs", 32'(idx_b), 12);
        chk("b_rows", 32'(rows_b), 4);
        chk("b_err", 32'(err_b), 0);

        // Manual results: same-cycle issue+return, drain to row handoff
        #1 auto_a = 0; row_ready_a = 0; start_a = 1;
        @(negedge clk);
        chk("d_first_valid", 32'(pair_valid_a), 1);
        chk("d_first_j", 32'(pair_j_a), 1);
        #1 start_a = 0; pair_ready_a = 1;
        @(negedge clk);
        chk("d_out_one", 32'(outstanding_a), 1);
        #1 res_man_a = 1;
        @(negedge clk);
        chk("d_same_cycle", 32'(outstanding_a), 1);
        chk("d_last_flag", 32'(pair_last_a), 1);
        #1 res_man_a = 0;
        @(negedge clk);
        chk("d_drain_out", 32'(outstanding_a), 2);
        chk("d_drain_valid", 32'(pair_valid_a), 0);
        #1 pair_ready_a = 0; res_man_a = 1; start_a = 1;
        @(negedge clk);
        chk("d_start_ignored", 32'(pair_valid_a), 0);
        chk("d_drain_out1", 32'(outstanding_a), 1);
        chk("d_no_row_yet", 32'(row_valid_a), 0);
        #1 start_a = 0;
        @(negedge clk);
        chk("d_row_valid", 32'(row_valid_a), 1);
        chk("d_out_zero", 32'(outstanding_a), 0);
        #1 res_man_a = 0;

        // row_ready held low: row held, nothing of row 1 issued
        repeat (5) begin
            @(negedge clk);
            chk("d_row_hold", 32'(row_valid_a), 1);
            chk("d_row_idx", 32'(row_idx_a), 0);
            chk("d_no_issue", 32'(pair_valid_a), 0);
        end
        #1 row_ready_a = 1;
        @(negedge clk);
        chk("d_row_released", 32'(row_valid_a), 0);
        chk("d_row1_valid", 32'(pair_valid_a), 1);
        chk("d_row1_i", 32'(pair_i_a), 1);
        chk("d_row1_j", 32'(pair_j_a), 0);
        chk("d_row1_first", 32'(pair_first_a), 1);

        // Three pairs of row 1 in flight, then async reset between edges
        #1 row_ready_a = 0; pair_ready_a = 1;
        @(negedge clk);
        chk("d_skip_diag", 32'(pair_j_a), 2);
        @(negedge clk);
        chk("d_row1_last_j", 32'(pair_j_a), 3);
        @(negedge clk);
        chk("d_out_three", 32'(outstanding_a), 3);
        #1 pair_ready_a = 0;
        #1 reset = 1'b1;
        #1;
        chk("ar_busy", 32'(busy_a), 0);
        chk("ar_pair_valid", 32'(pair_valid_a), 0);
        chk("ar_pair_i", 32'(pair_i_a), 0);
        chk("ar_pair_j", 32'(pair_j_a), 0);
        chk("ar_first_last", 32'({pair_first_a, pair_last_a}), 0);
        chk("ar_outstanding", 32'(outstanding_a), 0);
        chk("ar_row", 32'({row_valid_a, row_idx_a}), 0);
        chk("ar_done_err", 32'({done_a, err_a}), 0);
        @(negedge clk); #1 reset = 1'b0; res_man_a = 1;
        @(negedge clk);
        chk("ar_late_err", 32'(err_a), 1);
        chk("ar_late_out", 32'(outstanding_a), 0);
        #1 res_man_a = 0; start_a = 1;
        @(negedge clk);
        chk("ar_restart_valid", 32'(pair_valid_a), 1);
        chk("ar_restart_pair", 32'({pair_i_a, pair_j_a}), 32'h1);
        chk("ar_restart_first", 32'(pair_first_a), 1);
        chk("ar_err_sticky", 32'(err_a), 1);
        #1 start_a = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nbody_pair_scheduler.md
Name: nbody_pair_scheduler

Overview:
- Sequences the pipelined force calculator for one N-body timestep.
- Walks the outer index i over all bodies. For each i, issues every j != i to the body-fetch/force pipeline through a valid/ready handshake, keeping up to MAX_OUTSTANDING pairs in flight.
- Counts returned force results. Once all results for row i have returned, hands row i to the velocity/position update stage.
- Replaces the one-pair-at-a-time WAIT_FORCE loop so the force pipeline can accept one pair per cycle.

Parameters:
- N, 16, number of bodies; legal range 2..256.
- IDX_W, $clog2(N), width of body indices.
- MAX_OUTSTANDING, 8, maximum pairs issued but not yet returned; legal range 1..255.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a timestep; sampled only in IDLE or DONE
- busy  out  1  high in ISSUE, DRAIN, ROW_DONE
- done  out  1  high in DONE
- pair_valid  out  1  pair_i/pair_j valid
- pair_ready  in  1  fetch/force pipeline accepts the pair
- pair_i  out  IDX_W  outer body index
- pair_j  out  IDX_W  inner body index, never equal to pair_i
- pair_first  out  1  first pair of row i; accumulator clears on accept
- pair_last  out  1  last pair of row i
- res_valid  in  1  one force result returned this cycle
- row_valid  out  1  all N-1 results of row pair_i are returned
- row_ready  in  1  update stage accepts the row
- row_idx  out  IDX_W  row index, equal to i
- outstanding  out  CNT_W  current in-flight pair count
- err  out  1  sticky; res_valid received with outstanding==0

Behaviour:
- Reset (async) puts the block in IDLE. Reset values: i=0, j=0 (pair_j=0, row_idx=0), outstanding=0, err=0, issued=0, and all of busy, done, pair_valid, pair_first, pair_last, row_valid=0.
- Reset mid-operation aborts immediately. In-flight results arriving after reset raise err; upstream is expected to flush alongside.
- States: IDLE, ISSUE, DRAIN, ROW_DONE, DONE.
- IDLE: on start go to ISSUE next cycle. Load i=0, j=1, issued=0.
- DONE: done=1 is held. On start, restart exactly as from IDLE (done drops the next cycle).
- ISSUE:
  - pair_valid = (outstanding < MAX_OUTSTANDING), using the registered count only, with no same-cycle bypass from res_valid.
  - pair_first = (issued==0). pair_last = (issued==N-2).
  - On handshake (pair_valid && pair_ready): issued increments and j advances to the next index != i (j+1, or j+2 if j+1==i). Skipping costs zero cycles.
  - On the handshake with pair_last, go to DRAIN.
  - pair_i/pair_j hold stable while pair_valid && !pair_ready.
- DRAIN: pair_valid=0. When the next outstanding value is 0, go to ROW_DONE. This includes the cycle where the final res_valid arrives.
- ROW_DONE: row_valid=1, row_idx=i. On row_ready:
  - if i==N-1, go to DONE;
  - otherwise i increments, j is set to 0 (or 1 if the new i is 0, which cannot occur here), issued=0, and the state returns to ISSUE.
  - Rows never overlap: row i+1 issues only after row i is accepted.
- Outstanding counter:
  - +1 on issue handshake; -1 on res_valid; unchanged if both occur in the same cycle.
  - res_valid with outstanding==0 sets err and the counter stays 0.
  - The counter never exceeds MAX_OUTSTANDING.
- start while busy is ignored.
- The first pair of row 0 is (0,1).
- Throughput with pair_ready=1 and sufficient credit is one pair/cycle. Per row this costs N-1 issue cycles, plus drain to the last result, plus 1 ROW_DONE cycle minimum.

Test Plan:
- N=4, MAX=8, pair_ready=1, res_valid returned 6 cycles after each issue, row_ready=1 -> pair sequence (0,1)(0,2)(0,3)(1,0)(1,2)(1,3)(2,0)(2,1)(2,3)(3,0)(3,1)(3,2); pair_first on j=first and pair_last on j=last of each row; row_valid for rows 0..3 in order; done=1 and held; err=0.
- N=4, MAX=2, result latency 6 -> pair_valid drops after 2 issues; outstanding never exceeds 2; each issue follows the freeing res_valid by ≥1 cycle; sequence is identical to the first scenario.
- pair_ready toggled 1,0,0,1,… -> pair_i/pair_j held stable while stalled; no pair is skipped or duplicated; issued reaches exactly 3 per row.
- res_valid and an issue handshake in the same cycle with outstanding=1 -> outstanding stays 1. The final res_valid in DRAIN -> row_valid asserted on the next cycle.
- row_ready held 0 for 5 cycles in ROW_DONE -> row_valid and row_idx held; no pairs of the next row issued; proceeds one cycle after row_ready=1.
- Async reset asserted mid-row 1 with outstanding=3 -> all outputs go to reset values without a clock edge. A later res_valid sets err=1. Then start -> issues (0,1) again.
